medidor_periodo: RTL and testbench
==================================

MEDIDOR_PERIODO -- requirements
Module: medidor_periodo

Interface
REQ-001 SHALL have parameter MAX_PERIOD, default 1024, the largest measurable period in CLK cycles (MAX_PERIOD >= 2).
REQ-002 SHALL use localparam W = $clog2(MAX_PERIOD+1) as the PERIOD width.
REQ-003 CLK  input  1  single clock; all flops on rising edge.
REQ-004 RSTn  input  1  asynchronous reset, active low.
REQ-005 ENABLE  input  1  active-high measurement enable.
REQ-006 PULSE_IN  input  1  asynchronous periodic input whose rising-edge period is measured.
REQ-007 PERIOD  output  W  last measured period in CLK cycles, registered.
REQ-008 VALID  output  1  one-cycle pulse when PERIOD is updated.
REQ-009 OVERFLOW  output  1  sticky flag: the current period exceeded MAX_PERIOD.
REQ-010 MEASURING  output  1  high while in state MEASURE.

Function
REQ-011 PULSE_IN SHALL pass through a 2-flop synchronizer; a rising edge is detected when the synchronized value is 1 and its 1-cycle-delayed copy is 0.
REQ-012 The synchronizer and edge-detect flops SHALL run regardless of ENABLE.
REQ-013 Detection latency SHALL be 3 CLK edges from a PULSE_IN rise meeting setup to the detection cycle.
REQ-014 The FSM SHALL have states IDLE, MEASURE and OVF.
REQ-015 IDLE: on a detected edge with ENABLE=1, go to MEASURE and set cnt to 1; there is no VALID for this first edge.
REQ-016 MEASURE, no edge, cnt < MAX_PERIOD: cnt increments by 1.
REQ-017 MEASURE, edge detected: PERIOD gets cnt, VALID=1 for the next cycle, OVERFLOW clears, cnt resets to 1, and the FSM stays in MEASURE.
REQ-018 PERIOD therefore SHALL equal the exact distance in CLK cycles between two consecutive detected edges.
REQ-019 MEASURE, no edge, cnt == MAX_PERIOD: go to OVF and set OVERFLOW=1; PERIOD is unchanged and there is no VALID.
REQ-020 Edge coinciding with cnt == MAX_PERIOD: the edge wins, so PERIOD = MAX_PERIOD with VALID and no overflow.
REQ-021 OVF: cnt holds; on a detected edge, go to MEASURE with cnt=1 and no VALID; OVERFLOW stays 1 until the next VALID.
REQ-022 cnt SHALL be W bits, saturate-free by construction, and never wrap.
REQ-023 ENABLE=0 in any state: next state is IDLE, cnt=0, VALID=0; PERIOD and OVERFLOW hold; edges during this time are ignored.
REQ-024 ENABLE rising: measurement restarts from IDLE, so the first edge after enable produces no VALID.
REQ-025 The minimum detectable period is 2 cycles, since the synchronized input must be low for at least 1 cycle between edges.
REQ-026 VALID SHALL never be high for two consecutive cycles unless the period is 1, which is impossible; assertion: VALID is high for at most 1 of every 2 cycles.

Reset
REQ-027 RSTn=0 SHALL immediately force IDLE, cnt=0, PERIOD=0, VALID=0, OVERFLOW=0, MEASURING=0, and all synchronizer/edge flops to 0.
REQ-028 If PULSE_IN is high when RSTn is released, that SHALL count as a rising edge.
REQ-029 Reset asserted mid-MEASURE SHALL discard the partial count; the first edge after release arms the block with no VALID.

Verification (MAX_PERIOD=16 unless stated)
REQ-030 ENABLE=1, PULSE_IN rising every 10 cycles -> first edge gives no VALID; every later edge gives a 1-cycle VALID with PERIOD=10, MEASURING=1.
REQ-031 Edges 16 apart, then 17 apart -> PERIOD=16 with VALID, then OVERFLOW=1 exactly 16 cycles after the arming edge, with no VALID and PERIOD still 16; the next 5-cycle period gives PERIOD=5, VALID, and OVERFLOW=0.
REQ-032 Square wave with period 2 (1 high, 1 low) -> PERIOD=2 with VALID every other cycle.
REQ-033 Period 8; ENABLE dropped for 20 cycles, then raised -> no VALID while disabled, PERIOD holds 8; the first edge after re-enable gives no VALID and the second gives PERIOD=8.
REQ-034 RSTn pulsed low 5 cycles into a period-12 measurement -> all outputs 0 immediately; the next edge only arms; the following edge gives PERIOD=12.
REQ-035 Default MAX_PERIOD=1024, period 1024 -> PERIOD=1024, W=11, no OVERFLOW.

Source files
------------

// File: rtl/medidor_periodo_if.sv
// Measurement-side signals of medidor_periodo, grouped so the producer and
// the meter see the same parameterised PERIOD width.
interface medidor_periodo_if #(
  parameter int MAX_PERIOD = 1024
);
  localparam int W = $clog2(MAX_PERIOD + 1);

  logic         ENABLE;
  logic         PULSE_IN;
  logic [W-1:0] PERIOD;
  logic         VALID;
  logic         OVERFLOW;
  logic         MEASURING;

  modport master (
    output ENABLE, PULSE_IN,
    input  PERIOD, VALID, OVERFLOW, MEASURING
  );

  modport slave (
    input  ENABLE, PULSE_IN,
    output PERIOD, VALID, OVERFLOW, MEASURING
  );
endinterface

// File: rtl/medidor_periodo.sv
// Measures the distance in CLK cycles between consecutive rising edges of an
// asynchronous PULSE_IN; 2-flop synchronizer plus edge detect, no backpressure.
module medidor_periodo #(
  parameter int MAX_PERIOD = 1024
) (
  input  logic               CLK,
  input  logic               RSTn,
  medidor_periodo_if.slave   bus
);
  localparam int W = $clog2(MAX_PERIOD + 1);
  localparam logic [W-1:0] CNT_MAX = W'(MAX_PERIOD);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic [1:0] {IDLE, MEASURE, OVF} state_t;

  state_t       state_q, state_d;
  logic         sync1_q, sync1_d;
  logic         sync2_q, sync2_d;
  logic         dly_q, dly_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         meas_q, meas_d;
  logic         edge_det;

  // Synchronizer and edge flops ignore ENABLE so re-enabling never sees a stale edge.
  assign edge_det = sync2_q & ~dly_q;

  always_comb begin
    sync1_d  = bus.PULSE_IN;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;

    if (!bus.ENABLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        MEASURE: begin
          // An edge landing on cnt == MAX_PERIOD is still a valid measurement.
          if (edge_det) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            ovf_d    = 1'b0;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = OVF;
            ovf_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        OVF: begin
          if (edge_det) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    meas_d = (state_d == MEASURE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      meas_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      dly_q    <= dly_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      meas_q   <= meas_d;
    end
  end

  assign bus.PERIOD    = period_q;
  assign bus.VALID     = valid_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.MEASURING = meas_q;

  // The synchronized input must fall between edges, so VALID can never repeat.
  a_valid_single: assert property (@(posedge CLK) disable iff (!RSTn)
    valid_q |=> !valid_q);

endmodule

// File: tb/tb_medidor_periodo.sv
// Directed bench for medidor_periodo: MAX_PERIOD=16 instance for most
// scenarios plus a default-parameter instance for the 1024-cycle period.
module tb_medidor_periodo;
  localparam int MP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  medidor_periodo_if #(.MAX_PERIOD(MP)) bus ();
  medidor_periodo_if #(.MAX_PERIOD(1024)) bus2 ();

  medidor_periodo #(.MAX_PERIOD(MP)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  medidor_periodo dut_big (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle samples taken 1 time unit after each rising edge.
  logic       sv[$];
  logic [4:0] sp[$];
  logic       so[$];
  logic       sm[$];
  int         edge_q[$];
  int         en_lo_from = -1, en_lo_to = -1;
  int         rst_lo_from = -1, rst_lo_to = -1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.ENABLE = 1'b0;
    bus.PULSE_IN = 1'b0;
    bus2.ENABLE = 1'b0;
    bus2.PULSE_IN = 1'b0;
    en_lo_from = -1; en_lo_to = -1;
    rst_lo_from = -1; rst_lo_to = -1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Drives one-cycle PULSE_IN highs at the cycles in edge_q; ENABLE and
  // RSTn follow the low windows. Sample index c reflects the edge at iteration c.
  task automatic run(input int ncyc);
    sv.delete(); sp.delete(); so.delete(); sm.delete();
    for (int c = 0; c < ncyc; c++) begin
      bus.PULSE_IN = 1'b0;
      foreach (edge_q[i]) if (edge_q[i] == c) bus.PULSE_IN = 1'b1;
      bus.ENABLE = !(c >= en_lo_from && c <= en_lo_to);
      rst_n = !(c >= rst_lo_from && c <= rst_lo_to);
      tick;
      sv.push_back(bus.VALID);
      sp.push_back(bus.PERIOD);
      so.push_back(bus.OVERFLOW);
      sm.push_back(bus.MEASURING);
    end
    bus.PULSE_IN = 1'b0;
  endtask

  function automatic int count_valid(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (sv[i]) n++;
    return n;
  endfunction

  task automatic test_reset;
    do_reset;
    checks++; if (bus.PERIOD !== 5'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", bus.PERIOD); end
    checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.VALID); end
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.OVERFLOW); end
    checks++; if (bus.MEASURING !== 1'b0) begin errors++; $display("FAIL reset_measuring: got %b expected 0", bus.MEASURING); end
    // Build up a measurement, then assert reset between clock edges.
    edge_q = {0, 10};
    run(14);
    checks++; if (sv[12] !== 1'b1 || sp[12] !== 5'd10) begin errors++; $display("FAIL reset_pre_valid: got valid=%b period=%0d expected 1/10", sv[12], sp[12]); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.PERIOD !== 5'd0 || bus.MEASURING !== 1'b0) begin errors++; $display("FAIL reset_async: got period=%0d measuring=%b expected 0/0", bus.PERIOD, bus.MEASURING); end
  endtask

  task automatic test_pulse_high_at_release;
    rst_n = 1'b0;
    bus.ENABLE = 1'b1;
    bus.PULSE_IN = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    checks++; if (bus.MEASURING !== 1'b0) begin errors++; $display("FAIL release_early: got measuring=%b expected 0", bus.MEASURING); end
    tick;
    checks++; if (bus.MEASURING !== 1'b1) begin errors++; $display("FAIL release_arm: got measuring=%b expected 1", bus.MEASURING); end
    bus.PULSE_IN = 1'b0;
  endtask

  task automatic test_steady;
    do_reset;
    edge_q = {0, 10, 20, 30, 40};
    run(46);
    checks++; if (count_valid(0, 45) !== 4) begin errors++; $display("FAIL steady_count: got %0d expected 4", count_valid(0, 45)); end
    checks++; if (sv[2] !== 1'b0 || sm[2] !== 1'b1) begin errors++; $display("FAIL steady_arm: got valid=%b measuring=%b expected 0/1", sv[2], sm[2]); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (sv[10*k+2] !== 1'b1 || sp[10*k+2] !== 5'd10) begin
        errors++; $display("FAIL steady_edge%0d: got valid=%b period=%0d expected 1/10", k, sv[10*k+2], sp[10*k+2]);
      end
    end
    checks++; if (sm[45] !== 1'b1) begin errors++; $display("FAIL steady_measuring: got %b expected 1", sm[45]); end
  endtask

  task automatic test_overflow;
    do_reset;
    edge_q = {0, 16, 33, 38};
    run(44);
    checks++; if (sv[18] !== 1'b1 || sp[18] !== 5'd16 || so[18] !== 1'b0) begin errors++; $display("FAIL ovf_max_edge: got valid=%b period=%0d ovf=%b expected 1/16/0", sv[18], sp[18], so[18]); end
    checks++; if (so[33] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", so[33]); end
    checks++; if (so[34] !== 1'b1 || sp[34] !== 5'd16) begin errors++; $display("FAIL ovf_set: got ovf=%b period=%0d expected 1/16", so[34], sp[34]); end
    checks++; if (count_valid(19, 39) !== 0) begin errors++; $display("FAIL ovf_no_valid: got %0d expected 0", count_valid(19, 39)); end
    checks++; if (so[39] !== 1'b1 || sm[39] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got ovf=%b measuring=%b expected 1/1", so[39], sm[39]); end
    checks++; if (sv[40] !== 1'b1 || sp[40] !== 5'd5 || so[40] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got valid=%b period=%0d ovf=%b expected 1/5/0", sv[40], sp[40], so[40]); end
  endtask

  task automatic test_min_period;
    do_reset;
    edge_q = {0, 2, 4, 6, 8, 10, 12};
    run(18);
    checks++; if (count_valid(0, 17) !== 6) begin errors++; $display("FAIL min_count: got %0d expected 6", count_valid(0, 17)); end
    checks++; if (sv[2] !== 1'b0 || sv[5] !== 1'b0) begin errors++; $display("FAIL min_gaps: got v2=%b v5=%b expected 0/0", sv[2], sv[5]); end
    for (int i = 4; i <= 14; i += 2) begin
      checks++;
      if (sv[i] !== 1'b1 || sp[i] !== 5'd2) begin
        errors++; $display("FAIL min_edge_at_%0d: got valid=%b period=%0d expected 1/2", i, sv[i], sp[i]);
      end
    end
  endtask

  task automatic test_enable;
    do_reset;
    edge_q = {0, 8, 16, 24, 32, 40, 48, 56, 64};
    en_lo_from = 20; en_lo_to = 39;
    run(70);
    en_lo_from = -1; en_lo_to = -1;
    checks++; if (sv[10] !== 1'b1 || sp[10] !== 5'd8 || sv[18] !== 1'b1 || sp[18] !== 5'd8) begin errors++; $display("FAIL en_before: got v10=%b p10=%0d v18=%b p18=%0d expected 1/8/1/8", sv[10], sp[10], sv[18], sp[18]); end
    checks++; if (count_valid(20, 49) !== 0) begin errors++; $display("FAIL en_no_valid: got %0d expected 0", count_valid(20, 49)); end
    checks++; if (sm[30] !== 1'b0 || sp[30] !== 5'd8) begin errors++; $display("FAIL en_disabled: got measuring=%b period=%0d expected 0/8", sm[30], sp[30]); end
    checks++; if (sv[42] !== 1'b0 || sm[42] !== 1'b1) begin errors++; $display("FAIL en_rearm: got valid=%b measuring=%b expected 0/1", sv[42], sm[42]); end
    checks++; if (sv[50] !== 1'b1 || sp[50] !== 5'd8) begin errors++; $display("FAIL en_after: got valid=%b period=%0d expected 1/8", sv[50], sp[50]); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    edge_q = {0, 12, 24, 36};
    rst_lo_from = 19; rst_lo_to = 21;
    run(42);
    rst_lo_from = -1; rst_lo_to = -1;
    checks++; if (sv[14] !== 1'b1 || sp[14] !== 5'd12) begin errors++; $display("FAIL rmid_first: got valid=%b period=%0d expected 1/12", sv[14], sp[14]); end
    checks++; if (sp[19] !== 5'd0 || sm[19] !== 1'b0 || so[19] !== 1'b0) begin errors++; $display("FAIL rmid_cleared: got period=%0d measuring=%b ovf=%b expected 0/0/0", sp[19], sm[19], so[19]); end
    checks++; if (count_valid(15, 37) !== 0) begin errors++; $display("FAIL rmid_no_valid: got %0d expected 0", count_valid(15, 37)); end
    checks++; if (sm[26] !== 1'b1) begin errors++; $display("FAIL rmid_arm: got measuring=%b expected 1", sm[26]); end
    checks++; if (sv[38] !== 1'b1 || sp[38] !== 5'd12) begin errors++; $display("FAIL rmid_period: got valid=%b period=%0d expected 1/12", sv[38], sp[38]); end
  endtask

  task automatic test_default_max;
    int nv = 0;
    int vidx = -1;
    logic [10:0] vper = '0;
    logic ovs = 1'b0;
    do_reset;
    bus2.ENABLE = 1'b1;
    for (int c = 0; c < 1030; c++) begin
      bus2.PULSE_IN = (c == 0 || c == 1024);
      tick;
      if (bus2.VALID) begin nv++; vidx = c; vper = bus2.PERIOD; end
      if (bus2.OVERFLOW) ovs = 1'b1;
    end
    bus2.PULSE_IN = 1'b0;
    bus2.ENABLE = 1'b0;
    checks++; if (nv !== 1 || vidx !== 1026) begin errors++; $display("FAIL big_valid: got count=%0d at=%0d expected 1 at 1026", nv, vidx); end
    checks++; if (vper !== 11'd1024) begin errors++; $display("FAIL big_period: got %0d expected 1024", vper); end
    checks++; if (ovs !== 1'b0) begin errors++; $display("FAIL big_overflow: got %b expected 0", ovs); end
  endtask

  initial begin
    bus.ENABLE = 1'b0;
    bus.PULSE_IN = 1'b0;
    bus2.ENABLE = 1'b0;
    bus2.PULSE_IN = 1'b0;
    test_reset;
    test_pulse_high_at_release;
    test_steady;
    test_overflow;
    test_min_period;
    test_enable;
    test_reset_mid;
    test_default_max;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
